// File: rtl/fast_core_pkg.sv
// Shared types for the fast_core issue controller.
// Issue-queue and branch-FIFO entry layouts plus FSM states.
package fast_core_pkg;

    localparam int REG_IDX_W = 6;
    localparam int NUM_REGS  = 64;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0]          instr;
        logic [REG_IDX_W-1:0] src1;
        logic [REG_IDX_W-1:0] src2;
        logic [REG_IDX_W-1:0] dest;
        logic                 src1_used;
        logic                 src2_used;
        logic                 is_branch;
        logic                 is_load;
        logic [31:0]          pc;
        logic                 pred_taken;
    } iq_entry_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
    } br_entry_t;

endpackage

// File: rtl/fc_sync_fifo.sv
// Small synchronous FIFO with flush, shared by the issue queue
// and the outstanding-branch FIFO.
module fc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fast_core_issue_ctrl.sv
// In-order issue controller for fast_core: scoreboard-gated dispatch,
// branch tracking, predictor update and mispredict recovery.
module fast_core_issue_ctrl
    import fast_core_pkg::*;
#(
    parameter int IQ_DEPTH       = 4,
    parameter int BR_DEPTH       = 4,
    parameter int RECOVER_CYCLES = 2,
    parameter int CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [REG_IDX_W-1:0] in_src1,
    input  logic [REG_IDX_W-1:0] in_src2,
    input  logic [REG_IDX_W-1:0] in_dest,
    input  logic                 in_src1_used,
    input  logic                 in_src2_used,
    input  logic                 in_is_branch,
    input  logic                 in_is_load,
    input  logic [31:0]          in_pc,
    input  logic                 in_pred_taken,
    output logic                 fc_instr_valid,
    output logic [31:0]          fc_instr,
    output logic [REG_IDX_W-1:0] fc_src1_index,
    output logic [REG_IDX_W-1:0] fc_src2_index,
    output logic [REG_IDX_W-1:0] fc_dest_index,
    output logic                 fc_src1_valid,
    output logic                 fc_src2_valid,
    output logic                 fc_is_branch,
    output logic                 fc_is_load,
    input  logic                 fc_result_valid,
    input  logic [REG_IDX_W-1:0] fc_result_index,
    input  logic                 fc_branch_resolved,
    input  logic                 fc_branch_taken,
    output logic                 recovery_trigger,
    output logic                 update_valid,
    output logic [31:0]          update_pc,
    output logic                 update_taken,
    output logic                 update_correct,
    output logic [CNT_W-1:0]     branch_count,
    output logic [CNT_W-1:0]     mispredict_count,
    output logic                 err_orphan
);

    localparam int RW = $clog2(RECOVER_CYCLES + 1);

    iq_entry_t         in_entry;
    iq_entry_t         iq_head;
    br_entry_t         br_in;
    br_entry_t         br_head;
    logic              iq_full;
    logic              iq_empty;
    logic              iq_push;
    logic              br_full;
    logic              br_empty;
    logic              br_push;
    state_t            state;
    logic [RW-1:0]     rec_cnt;
    logic [NUM_REGS-1:0] sb;
    logic [NUM_REGS-1:0] sb_next;
    logic              src1_ok;
    logic              src2_ok;
    logic              dispatch;
    logic              resolve;
    logic              correct;
    logic              mispredict;
    logic              flush;

    assign in_entry = '{
        instr:      in_instr,
        src1:       in_src1,
        src2:       in_src2,
        dest:       in_dest,
        src1_used:  in_src1_used,
        src2_used:  in_src2_used,
        is_branch:  in_is_branch,
        is_load:    in_is_load,
        pc:         in_pc,
        pred_taken: in_pred_taken
    };

    assign in_ready = (state == ST_RUN) && !iq_full;
    assign iq_push  = in_valid && in_ready;
    assign flush    = recovery_trigger;

    assign src1_ok  = !iq_head.src1_used || sb[iq_head.src1];
    assign src2_ok  = !iq_head.src2_used || sb[iq_head.src2];
    assign dispatch = (state == ST_RUN) && !flush && !iq_empty &&
                      src1_ok && src2_ok &&
                      (!iq_head.is_branch || !br_full);

    assign br_push = dispatch && iq_head.is_branch;
    assign br_in   = '{pc: iq_head.pc, pred_taken: iq_head.pred_taken};

    assign resolve    = fc_branch_resolved && (state == ST_RUN) && !br_empty;
    assign correct    = (fc_branch_taken == br_head.pred_taken);
    assign mispredict = resolve && !correct;

    fc_sync_fifo #(
        .WIDTH ($bits(iq_entry_t)),
        .DEPTH (IQ_DEPTH)
    ) u_iq (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (iq_push),
        .wdata (in_entry),
        .pop   (dispatch),
        .rdata (iq_head),
        .full  (iq_full),
        .empty (iq_empty)
    );

    fc_sync_fifo #(
        .WIDTH ($bits(br_entry_t)),
        .DEPTH (BR_DEPTH)
    ) u_br (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (br_push),
        .wdata (br_in),
        .pop   (resolve),
        .rdata (br_head),
        .full  (br_full),
        .empty (br_empty)
    );

    // Writeback sets, dispatch clears afterwards so the clear wins.
    always_comb begin
        sb_next = sb;
        if (fc_result_valid && (state == ST_RUN)) begin
            sb_next[fc_result_index] = 1'b1;
        end
        if (dispatch && !iq_head.is_branch && (iq_head.dest != '0)) begin
            sb_next[iq_head.dest] = 1'b0;
        end
        if (flush) begin
            sb_next = '1;
        end
        sb_next[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= ST_RUN;
            rec_cnt          <= '0;
            sb               <= '1;
            fc_instr_valid   <= 1'b0;
            fc_instr         <= '0;
            fc_src1_index    <= '0;
            fc_src2_index    <= '0;
            fc_dest_index    <= '0;
            fc_src1_valid    <= 1'b0;
            fc_src2_valid    <= 1'b0;
            fc_is_branch     <= 1'b0;
            fc_is_load       <= 1'b0;
            recovery_trigger <= 1'b0;
            update_valid     <= 1'b0;
            update_pc        <= '0;
            update_taken     <= 1'b0;
            update_correct   <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
            err_orphan       <= 1'b0;
        end else begin
            sb               <= sb_next;
            fc_instr_valid   <= dispatch;
            update_valid     <= resolve;
            recovery_trigger <= mispredict;
            if (dispatch) begin
                fc_instr      <= iq_head.instr;
                fc_src1_index <= iq_head.src1;
                fc_src2_index <= iq_head.src2;
                fc_dest_index <= iq_head.dest;
                fc_src1_valid <= iq_head.src1_used;
                fc_src2_valid <= iq_head.src2_used;
                fc_is_branch  <= iq_head.is_branch;
                fc_is_load    <= iq_head.is_load;
            end
            if (resolve) begin
                update_pc      <= br_head.pc;
                update_taken   <= fc_branch_taken;
                update_correct <= correct;
                if (branch_count != '1) begin
                    branch_count <= branch_count + 1'b1;
                end
            end
            if (mispredict && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + 1'b1;
            end
            if (fc_branch_resolved && (state == ST_RUN) && br_empty) begin
                err_orphan <= 1'b1;
            end
            case (state)
                ST_RUN: begin
                    if (mispredict) begin
                        state   <= ST_RECOVER;
                        rec_cnt <= RW'(RECOVER_CYCLES - 1);
                    end
                end
                ST_RECOVER: begin
                    if (rec_cnt == '0) begin
                        state <= ST_RUN;
                    end else begin
                        rec_cnt <= rec_cnt - 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fast_core_issue_ctrl.sv
// Bench for fast_core_issue_ctrl: vector table, scoreboard queues
// for dispatch and predictor updates, and hand-written corner cases.
module tb_fast_core_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [5:0]  in_src1;
    logic [5:0]  in_src2;
    logic [5:0]  in_dest;
    logic        in_src1_used;
    logic        in_src2_used;
    logic        in_is_branch;
    logic        in_is_load;
    logic [31:0] in_pc;
    logic        in_pred_taken;
    logic        fc_instr_valid;
    logic [31:0] fc_instr;
    logic [5:0]  fc_src1_index;
    logic [5:0]  fc_src2_index;
    logic [5:0]  fc_dest_index;
    logic        fc_src1_valid;
    logic        fc_src2_valid;
    logic        fc_is_branch;
    logic        fc_is_load;
    logic        fc_result_valid;
    logic [5:0]  fc_result_index;
    logic        fc_branch_resolved;
    logic        fc_branch_taken;
    logic        recovery_trigger;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic        update_correct;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;
    logic        err_orphan;

    always #5 clk = ~clk;

    fast_core_issue_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_instr           (in_instr),
        .in_src1            (in_src1),
        .in_src2            (in_src2),
        .in_dest            (in_dest),
        .in_src1_used       (in_src1_used),
        .in_src2_used       (in_src2_used),
        .in_is_branch       (in_is_branch),
        .in_is_load         (in_is_load),
        .in_pc              (in_pc),
        .in_pred_taken      (in_pred_taken),
        .fc_instr_valid     (fc_instr_valid),
        .fc_instr           (fc_instr),
        .fc_src1_index      (fc_src1_index),
        .fc_src2_index      (fc_src2_index),
        .fc_dest_index      (fc_dest_index),
        .fc_src1_valid      (fc_src1_valid),
        .fc_src2_valid      (fc_src2_valid),
        .fc_is_branch       (fc_is_branch),
        .fc_is_load         (fc_is_load),
        .fc_result_valid    (fc_result_valid),
        .fc_result_index    (fc_result_index),
        .fc_branch_resolved (fc_branch_resolved),
        .fc_branch_taken    (fc_branch_taken),
        .recovery_trigger   (recovery_trigger),
        .update_valid       (update_valid),
        .update_pc          (update_pc),
        .update_taken       (update_taken),
        .update_correct     (update_correct),
        .branch_count       (branch_count),
        .mispredict_count   (mispredict_count),
        .err_orphan         (err_orphan)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [5:0]  s1;
        logic [5:0]  s2;
        logic [5:0]  d;
        logic        u1;
        logic        u2;
        logic        br;
        logic        ld;
    } disp_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic        correct;
    } upd_t;

    typedef struct packed {
        disp_t ins;
        logic  exp_ready;
    } vec_t;

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    disp_t  exp_q[$];
    upd_t   upd_q[$];
    int     disp_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input disp_t e, input logic [31:0] pc,
                         input logic pred);
        in_valid      = 1'b1;
        in_instr      = e.instr;
        in_src1       = e.s1;
        in_src2       = e.s2;
        in_dest       = e.d;
        in_src1_used  = e.u1;
        in_src2_used  = e.u2;
        in_is_branch  = e.br;
        in_is_load    = e.ld;
        in_pc         = pc;
        in_pred_taken = pred;
    endtask

    // Dispatch and predictor-update scoreboards
    always @(negedge clk) begin
        disp_t e;
        upd_t  u;
        if (rst_n && fc_instr_valid) begin
            disp_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dispatch: got instr %h required none",
                         fc_instr);
            end else begin
                e = exp_q.pop_front();
                chk("dispatch_fields",
                    64'({fc_instr, fc_src1_index, fc_src2_index,
                         fc_dest_index, fc_src1_valid, fc_src2_valid,
                         fc_is_branch, fc_is_load}),
                    64'(e));
            end
        end
        if (rst_n && update_valid) begin
            if (upd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_update: got pc %h required none",
                         update_pc);
            end else begin
                u = upd_q.pop_front();
                chk("update_fields",
                    64'({update_pc, update_taken, update_correct}), 64'(u));
                chk("recovery_with_update", 64'(recovery_trigger),
                    64'(!u.correct));
            end
        end
        if (rst_n && recovery_trigger && !update_valid) begin
            checks++;
            errors++;
            $display("FAIL lone_recovery: got recovery_trigger=1 required 0");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[5];
        disp_t add_i;
        disp_t addi_i;
        disp_t br_i;
        disp_t op_i;
        disp_t brs[5];
        int    ndisp;

        tbl[0] = '{'{32'h00A00533, 6'd0, 6'd0, 6'd10, 1'b1, 1'b1,
                     1'b0, 1'b0}, 1'b1};
        tbl[1] = '{'{32'h001005B3, 6'd1, 6'd2, 6'd11, 1'b1, 1'b0,
                     1'b0, 1'b0}, 1'b1};
        tbl[2] = '{'{32'h00002603, 6'd0, 6'd0, 6'd12, 1'b1, 1'b0,
                     1'b0, 1'b1}, 1'b1};
        tbl[3] = '{'{32'h00C006B3, 6'd3, 6'd1, 6'd13, 1'b0, 1'b1,
                     1'b0, 1'b0}, 1'b1};
        tbl[4] = '{'{32'h00D00733, 6'd5, 6'd6, 6'd14, 1'b0, 1'b0,
                     1'b0, 1'b0}, 1'b1};
        add_i  = '{32'h000000B3, 6'd0, 6'd0, 6'd1, 1'b1, 1'b1, 1'b0, 1'b0};
        addi_i = '{32'h00508113, 6'd1, 6'd0, 6'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        br_i   = '{32'h00000063, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        in_src1 = '0;
        in_src2 = '0;
        in_dest = '0;
        in_src1_used = 1'b0;
        in_src2_used = 1'b0;
        in_is_branch = 1'b0;
        in_is_load = 1'b0;
        in_pc = '0;
        in_pred_taken = 1'b0;
        fc_result_valid = 1'b0;
        fc_result_index = '0;
        fc_branch_resolved = 1'b0;
        fc_branch_taken = 1'b0;
        repeat (2) step();
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_fc_valid", 64'(fc_instr_valid), 64'(0));
        chk("rst_update_valid", 64'(update_valid), 64'(0));
        chk("rst_recovery", 64'(recovery_trigger), 64'(0));
        chk("rst_branch_count", 64'(branch_count), 64'(0));
        chk("rst_mispredict_count", 64'(mispredict_count), 64'(0));
        chk("rst_err_orphan", 64'(err_orphan), 64'(0));
        rst_n = 1'b1;
        step();

        // Dependency stall and writeback without bypass
        drive(add_i, 32'h1000, 1'b0);
        chk("dep_ready", 64'(in_ready), 64'(1));
        exp_q.push_back(add_i);
        step();
        drive(addi_i, 32'h1004, 1'b0);
        exp_q.push_back(addi_i);
        step();
        in_valid = 1'b0;
        chk("dep_add_disp", 64'(fc_instr_valid), 64'(1));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("dep_stall", 64'(fc_instr_valid), 64'(0));
        end
        fc_result_valid = 1'b1;
        fc_result_index = 6'd1;
        step();
        fc_result_valid = 1'b0;
        chk("dep_no_bypass", 64'(fc_instr_valid), 64'(0));
        step();
        chk("dep_addi_disp", 64'(fc_instr_valid), 64'(1));
        chk("dep_addi_instr", 64'(fc_instr), 64'(addi_i.instr));
        step();

        // Independent ops back-to-back from the vector table
        disp_cyc.delete();
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].ins, 32'h1100 + 32'(i * 4), 1'b0);
            chk("alu_ready", 64'(in_ready), 64'(tbl[i].exp_ready));
            exp_q.push_back(tbl[i].ins);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        chk("alu_disp_count", 64'(disp_cyc.size()), 64'(5));
        for (int i = 1; i < disp_cyc.size(); i++) begin
            chk("alu_consecutive", 64'(disp_cyc[i] - disp_cyc[i-1]), 64'(1));
        end

        // Correctly predicted branch
        drive(br_i, 32'h2000, 1'b1);
        exp_q.push_back(br_i);
        step();
        in_valid = 1'b0;
        repeat (2) step();
        upd_q.push_back('{32'h2000, 1'b1, 1'b1});
        fc_branch_resolved = 1'b1;
        fc_branch_taken = 1'b1;
        step();
        fc_branch_resolved = 1'b0;
        chk("br_update_valid", 64'(update_valid), 64'(1));
        chk("br_update_pc", 64'(update_pc), 64'h2000);
        chk("br_update_correct", 64'(update_correct), 64'(1));
        chk("br_no_recovery", 64'(recovery_trigger), 64'(0));
        chk("br_count", 64'(branch_count), 64'(1));
        step();
        chk("br_update_pulse", 64'(update_valid), 64'(0));

        // Mispredict with younger ops still queued behind it
        drive(br_i, 32'h2004, 1'b0);
        exp_q.push_back(br_i);
        step();
        for (int i = 0; i < 3; i++) begin
            op_i = '{32'h00A00033 + 32'(i), 6'd10, 6'd0, 6'(20 + i),
                     1'b1, 1'b0, 1'b0, 1'b0};
            drive(op_i, 32'h2008 + 32'(i * 4), 1'b0);
            chk("mis_queue_ready", 64'(in_ready), 64'(1));
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();
        ndisp = disp_cyc.size();
        upd_q.push_back('{32'h2004, 1'b1, 1'b0});
        fc_branch_resolved = 1'b1;
        fc_branch_taken = 1'b1;
        step();
        fc_branch_resolved = 1'b0;
        chk("mis_recovery", 64'(recovery_trigger), 64'(1));
        chk("mis_update_correct", 64'(update_correct), 64'(0));
        chk("mis_in_ready_1", 64'(in_ready), 64'(0));
        chk("mis_count", 64'(mispredict_count), 64'(1));
        chk("mis_branch_count", 64'(branch_count), 64'(2));
        step();
        chk("mis_in_ready_2", 64'(in_ready), 64'(0));
        chk("mis_recovery_pulse", 64'(recovery_trigger), 64'(0));
        step();
        chk("mis_in_ready_back", 64'(in_ready), 64'(1));
        repeat (4) step();
        chk("mis_flushed", 64'(disp_cyc.size()), 64'(ndisp));

        // Branch FIFO full holds the fifth branch
        disp_cyc.delete();
        for (int i = 0; i < 5; i++) begin
            brs[i] = br_i;
            brs[i].instr = 32'h00000063 | (32'(i) << 20);
            drive(brs[i], 32'h3000 + 32'(i * 4), 1'(i));
            chk("bfull_ready", 64'(in_ready), 64'(1));
            exp_q.push_back(brs[i]);
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("bfull_held", 64'(disp_cyc.size()), 64'(4));
        upd_q.push_back('{32'h3000, 1'b0, 1'b1});
        fc_branch_resolved = 1'b1;
        fc_branch_taken = 1'b0;
        step();
        fc_branch_resolved = 1'b0;
        chk("bfull_not_yet", 64'(fc_instr_valid), 64'(0));
        step();
        chk("bfull_fifth_disp", 64'(fc_instr_valid), 64'(1));
        chk("bfull_fifth_instr", 64'(fc_instr), 64'(brs[4].instr));
        for (int i = 1; i < 5; i++) begin
            upd_q.push_back('{32'h3000 + 32'(i * 4), 1'(i), 1'b1});
            fc_branch_resolved = 1'b1;
            fc_branch_taken = 1'(i);
            step();
        end
        fc_branch_resolved = 1'b0;
        step();
        chk("bfull_branch_count", 64'(branch_count), 64'(7));
        chk("bfull_mispredicts", 64'(mispredict_count), 64'(1));

        // Orphan resolve, then reset mid-operation
        fc_branch_resolved = 1'b1;
        fc_branch_taken = 1'b1;
        step();
        fc_branch_resolved = 1'b0;
        chk("orphan_flag", 64'(err_orphan), 64'(1));
        chk("orphan_no_update", 64'(update_valid), 64'(0));
        step();
        chk("orphan_sticky", 64'(err_orphan), 64'(1));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst2_err_orphan", 64'(err_orphan), 64'(0));
        chk("rst2_in_ready", 64'(in_ready), 64'(1));
        chk("rst2_branch_count", 64'(branch_count), 64'(0));
        chk("rst2_mispredict_count", 64'(mispredict_count), 64'(0));
        repeat (3) step();
        chk("dispatch_queue_drained", 64'(exp_q.size()), 64'(0));
        chk("update_queue_drained", 64'(upd_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
